uart_tx_fifo: RTL and testbench

Parametrised, buffered UART transmitter for the AMBA peripheral subsystem. It succeeds the fixed-rate sender with a programmable baud divisor, a TX FIFO with valid/ready write port, LSB/MSB-first selection, mark parity, CTS flow control and break generation. Frame format is latched per frame, so back-to-back frames leave no idle gap. The register block drives its write port and configuration; `uart_txd` goes to the pad.

---
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_tx_fifo.sv | 141 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: TX FIFO write port; master = register block, slave = transmitter
// wr_valid/wr_data/wr_ready: write handshake; fifo_flush: sync clear; fifo_level: occupancy
interface uart_tx_fifo_if #(parameter int LVL_W = 4) ();
  logic wr_valid;
  logic [15:0] wr_data;
  logic wr_ready;
  logic fifo_flush;
  logic [LVL_W-1:0] fifo_level;
  modport master (output wr_valid, wr_data, fifo_flush, input wr_ready, fifo_level);
  modport slave (input wr_valid, wr_data, fifo_flush, output wr_ready, fifo_level);
endinterface

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with programmable baud, parity, stop bits, CTS and break
// clk/rstn: clock, async active-low reset; baud_div/data_num/check_mode/stop_num/lsb_first: frame format
// tx_en/cts_n/break_req: start gating and break; wr: FIFO write port; tx_busy/tx_done/uart_txd: status and line
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W = 16,
  parameter int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic [DIV_W-1:0] baud_div,
  input  logic [3:0] data_num,
  input  logic [1:0] check_mode,
  input  logic [1:0] stop_num,
  input  logic lsb_first,
  input  logic tx_en,
  input  logic cts_n,
  input  logic break_req,
  uart_tx_fifo_if.slave wr,
  output logic tx_busy,
  output logic tx_done,
  output logic uart_txd
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic [15:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [3:0] bit_q, bit_d, dnum_q, dnum_d, idx;
  logic [1:0] mode_q, mode_d, snum_q, snum_d;
  logic [15:0] data_q, data_d;
  logic lsb_q, lsb_d, guard_q, guard_d, txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic full, empty, push, go, bit_end, last_stop, start, par;
  assign full = level_q == LVL_W'(FIFO_DEPTH);
  assign empty = level_q == '0;
  assign push = wr.wr_valid && !full && !wr.fifo_flush;
  assign go = tx_en && !empty && !cts_n && !break_req;
  assign bit_end = cnt_q == div_q;
  assign last_stop = state_q == STOP && bit_end && bit_q == {2'b00, snum_q};
  // a frame starts from IDLE or directly out of the last stop bit (back-to-back)
  assign start = go && (state_q == IDLE || last_stop);
  assign par = (&mode_q) ? 1'b1 : mode_q[0] ? ~^data_q : ^data_q;
  assign wr.wr_ready = !full;
  assign wr.fifo_level = level_q;
  assign tx_busy = busy_q;
  assign tx_done = done_q;
  assign uart_txd = txd_q;
  always_comb begin
    wptr_d = wr.fifo_flush ? '0 : wptr_q + AW'(push);
    rptr_d = wr.fifo_flush ? '0 : rptr_q + AW'(start);
    level_d = wr.fifo_flush ? '0 : level_q + LVL_W'(push) - LVL_W'(start);
    div_d = start ? baud_div : div_q;
    dnum_d = start ? data_num : dnum_q;
    mode_d = start ? check_mode : mode_q;
    snum_d = start ? stop_num : snum_q;
    lsb_d = start ? lsb_first : lsb_q;
    data_d = start ? mem_q[rptr_q] & (16'hffff >> (4'd15 - data_num)) : data_q;
    state_d = state_q;
    cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    bit_d = bit_q;
    guard_d = guard_q;
    done_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        guard_d = 1'b0;
        state_d = go ? START : break_req ? BREAK : IDLE;
      end
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        bit_d = bit_q == dnum_q ? '0 : bit_q + 1'b1;
        state_d = bit_q != dnum_q ? DATA : mode_q != 2'b00 ? PARITY : STOP;
      end
      PARITY: if (bit_end) begin
        state_d = STOP;
        bit_d = '0;
      end
      STOP: if (bit_end) begin
        bit_d = last_stop ? '0 : bit_q + 1'b1;
        done_d = last_stop;
        guard_d = 1'b0;
        state_d = !last_stop ? STOP : go ? START : break_req ? BREAK : IDLE;
      end
      BREAK: begin
        // line held low until release, then high for one bit period of the live divisor
        cnt_d = guard_q ? cnt_q + 1'b1 : '0;
        guard_d = guard_q || !break_req;
        state_d = guard_q && cnt_q == baud_div ? IDLE : BREAK;
      end
      default: state_d = IDLE;
    endcase
    // the line is registered from the next state so it changes on the same edge as the state
    idx = lsb_q ? bit_d : dnum_q - bit_d;
    txd_d = state_d == START ? 1'b0 : state_d == DATA ? data_q[idx] : state_d == PARITY ? par :
            state_d == BREAK ? guard_d : 1'b1;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk)
    if (push) mem_q[wptr_q] <= wr.wr_data;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q <= IDLE;
      wptr_q <= '0;
      rptr_q <= '0;
      level_q <= '0;
      cnt_q <= '0;
      div_q <= '0;
      bit_q <= '0;
      dnum_q <= '0;
      mode_q <= '0;
      snum_q <= '0;
      lsb_q <= 1'b1;
      data_q <= '0;
      guard_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      level_q <= level_d;
      cnt_q <= cnt_d;
      div_q <= div_d;
      bit_q <= bit_d;
      dnum_q <= dnum_d;
      mode_q <= mode_d;
      snum_q <= snum_d;
      lsb_q <= lsb_d;
      data_q <= data_d;
      guard_q <= guard_d;
      txd_q <= txd_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed scoreboard bench for uart_tx_fifo
module tb_uart_tx_fifo;
  localparam int DEPTH = 8;
  typedef struct {
    logic [31:0] bits;
    int len;
    int div;
  } frame_t;
  logic clk = 1'b0;
  logic rstn;
  logic [15:0] baud_div;
  logic [3:0] data_num;
  logic [1:0] check_mode, stop_num;
  logic lsb_first, tx_en, cts_n, break_req;
  logic tx_busy, tx_done, txd;
  int n_assert = 0;
  int n_fail = 0;
  int model_level = 0;
  frame_t exp_q[$];
  uart_tx_fifo_if #(.LVL_W(4)) ifc ();
  uart_tx_fifo #(.FIFO_DEPTH(DEPTH), .DIV_W(16), .LVL_W(4)) dut (
    .clk(clk), .rstn(rstn), .baud_div(baud_div), .data_num(data_num), .check_mode(check_mode),
    .stop_num(stop_num), .lsb_first(lsb_first), .tx_en(tx_en), .cts_n(cts_n), .break_req(break_req),
    .wr(ifc), .tx_busy(tx_busy), .tx_done(tx_done), .uart_txd(txd)
  );
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic frame_t model(input logic [15:0] d);
    frame_t f;
    logic [15:0] m;
    int n, ones;
    m = '0;
    for (int i = 0; i <= 32'(data_num); i++) m[i] = d[i];
    ones = $countones(m);
    f.bits = '0;
    n = 1;
    for (int i = 0; i <= 32'(data_num); i++) begin
      f.bits[n] = lsb_first ? m[i] : m[32'(data_num) - i];
      n++;
    end
    if (check_mode != 2'b00) begin
      f.bits[n] = check_mode == 2'b11 ? 1'b1 : check_mode == 2'b01 ? (ones % 2 == 0) : (ones % 2 == 1);
      n++;
    end
    for (int s = 0; s <= 32'(stop_num); s++) begin
      f.bits[n] = 1'b1;
      n++;
    end
    f.len = n;
    f.div = 32'(baud_div);
    return f;
  endfunction

  task automatic write(input logic [15:0] d);
    logic exp_rdy;
    exp_rdy = model_level < DEPTH;
    ifc.wr_valid = 1'b1;
    ifc.wr_data = d;
    check("wr_ready", ifc.wr_ready, exp_rdy);
    @(negedge clk);
    ifc.wr_valid = 1'b0;
    if (exp_rdy) begin
      model_level++;
      exp_q.push_back(model(d));
    end
    check("level_after_write", ifc.fifo_level, model_level);
  endtask

  // act 1 raises cts_n, act 2 raises break_req, at frame cycle act_at
  task automatic rx_frame(input int exp_wait, input int act_at, input int act);
    frame_t f;
    int w, cyc, errs;
    w = 0;
    while (txd !== 1'b0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    check("start_wait", w, exp_wait);
    if (w >= 300) return;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL scoreboard: observed unexpected frame expected none");
      return;
    end
    f = exp_q.pop_front();
    model_level--;
    check("level_at_start", ifc.fifo_level, model_level);
    check("busy_at_start", tx_busy, 1);
    cyc = 0;
    for (int b = 0; b < f.len; b++) begin
      errs = 0;
      for (int c = 0; c <= f.div; c++) begin
        if (cyc == act_at) begin
          if (act == 1) cts_n = 1'b1;
          else break_req = 1'b1;
        end
        if (txd !== f.bits[b] || (cyc > 0 && tx_done !== 1'b0)) errs++;
        @(negedge clk);
        cyc++;
      end
      check($sformatf("frame_bit%0d", b), errs, 0);
    end
    check("tx_done", tx_done, 1);
  endtask

  initial begin
    int errs;
    rstn = 1'b0;
    baud_div = 16'd3;
    data_num = 4'd7;
    check_mode = 2'b00;
    stop_num = 2'b00;
    lsb_first = 1'b1;
    tx_en = 1'b0;
    cts_n = 1'b0;
    break_req = 1'b0;
    ifc.wr_valid = 1'b0;
    ifc.wr_data = '0;
    ifc.fifo_flush = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1);
    check("rst_wr_ready", ifc.wr_ready, 1);
    check("rst_level", ifc.fifo_level, 0);
    check("rst_busy", tx_busy, 0);
    check("rst_done", tx_done, 0);
    rstn = 1'b1;
    @(negedge clk);

    // 8N1 LSB first, 4 clocks per bit
    tx_en = 1'b1;
    write(16'h0035);
    rx_frame(1, -1, 0);
    @(negedge clk);
    check("idle_busy", tx_busy, 0);

    // MSB first, 5 data bits, two stop bits, each parity mode
    data_num = 4'd4;
    lsb_first = 1'b0;
    stop_num = 2'd1;
    check_mode = 2'b01;
    baud_div = 16'd2;
    write(16'h0013);
    rx_frame(1, -1, 0);
    check_mode = 2'b10;
    baud_div = 16'd0;
    write(16'h0013);
    rx_frame(1, -1, 0);
    check_mode = 2'b11;
    baud_div = 16'd1;
    write(16'hFFF3);
    rx_frame(1, -1, 0);

    // widest frame: 16 data bits, even parity, 4 stop bits, 1 clk/bit
    data_num = 4'd15;
    lsb_first = 1'b1;
    stop_num = 2'd3;
    check_mode = 2'b10;
    baud_div = 16'd0;
    write(16'hBEEF);
    rx_frame(1, -1, 0);

    // back-to-back
    data_num = 4'd7;
    stop_num = 2'd0;
    check_mode = 2'b00;
    baud_div = 16'd1;
    tx_en = 1'b0;
    write(16'h00A5);
    write(16'h003C);
    write(16'h000F);
    tx_en = 1'b1;
    rx_frame(1, -1, 0);
    rx_frame(0, -1, 0);
    rx_frame(0, -1, 0);

    // full and flush; flush beats a same-cycle write
    tx_en = 1'b0;
    for (int i = 0; i < 9; i++) write(16'(i + 1));
    check("full_ready", ifc.wr_ready, 0);
    check("full_level", ifc.fifo_level, DEPTH);
    ifc.fifo_flush = 1'b1;
    ifc.wr_valid = 1'b1;
    @(negedge clk);
    ifc.fifo_flush = 1'b0;
    ifc.wr_valid = 1'b0;
    model_level = 0;
    exp_q.delete();
    check("flush_level", ifc.fifo_level, 0);
    check("flush_ready", ifc.wr_ready, 1);

    // flow control, plus simultaneous write and pop
    tx_en = 1'b1;
    cts_n = 1'b1;
    write(16'h005A);
    errs = 0;
    repeat (10) begin
      if (txd !== 1'b1 || tx_busy !== 1'b0) errs++;
      @(negedge clk);
    end
    check("cts_hold", errs, 0);
    cts_n = 1'b0;
    ifc.wr_valid = 1'b1;
    ifc.wr_data = 16'h0081;
    check("wr_ready_pop", ifc.wr_ready, 1);
    @(negedge clk);
    ifc.wr_valid = 1'b0;
    model_level++;
    exp_q.push_back(model(16'h0081));
    rx_frame(0, 5, 1);
    errs = 0;
    repeat (6) begin
      if (txd !== 1'b1 || tx_busy !== 1'b0) errs++;
      @(negedge clk);
    end
    check("cts_hold2", errs, 0);
    cts_n = 1'b0;
    rx_frame(1, -1, 0);

    // break requested mid-frame, no pop while breaking, guard bit afterwards
    baud_div = 16'd3;
    write(16'h0096);
    rx_frame(1, 6, 2);
    errs = 0;
    repeat (8) begin
      if (txd !== 1'b0 || tx_busy !== 1'b1) errs++;
      @(negedge clk);
    end
    check("break_low", errs, 0);
    write(16'h000F);
    errs = 0;
    repeat (6) begin
      if (txd !== 1'b0 || ifc.fifo_level !== 4'd1) errs++;
      @(negedge clk);
    end
    check("break_no_pop", errs, 0);
    break_req = 1'b0;
    @(negedge clk);
    errs = 0;
    repeat (4) begin
      if (txd !== 1'b1 || tx_busy !== 1'b1) errs++;
      @(negedge clk);
    end
    check("break_guard", errs, 0);
    check("idle_after_guard", tx_busy, 0);
    rx_frame(1, -1, 0);

    // asynchronous reset mid-frame discards the FIFO
    tx_en = 1'b0;
    write(16'h0055);
    write(16'h00AA);
    tx_en = 1'b1;
    repeat (8) @(negedge clk);
    check("pre_reset_busy", tx_busy, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_txd", txd, 1);
    check("arst_level", ifc.fifo_level, 0);
    check("arst_busy", tx_busy, 0);
    check("arst_ready", ifc.wr_ready, 1);
    @(negedge clk);
    rstn = 1'b1;
    model_level = 0;
    exp_q.delete();
    errs = 0;
    repeat (20) begin
      if (txd !== 1'b1 || tx_busy !== 1'b0 || ifc.fifo_level !== 4'd0) errs++;
      @(negedge clk);
    end
    check("post_reset_idle", errs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
